bp_cfg_loader: RTL and testbench

- Boot-time configuration sequencer for the tile array.
- Reads the selected processor configuration from the aviary's config array (all_cfgs_gp[cfg_p]).
- Turns that configuration into a fixed series of per-core config-register writes on a valid/ready link, then releases each core from freeze.
- Sits between chip reset and the core tiles' config-bus responders; it is the runtime consumer of the static configuration tables.

---
 rtl/bp_cfg_loader_pkg.sv | 61 ++++++
 rtl/bp_cfg_loader_credits.sv | 43 ++++
 rtl/bp_cfg_loader.sv | 141 ++++++++++++++
 tb/tb_bp_cfg_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_cfg_loader_pkg.sv
// Shared types for the boot-time config loader: processor geometry table,
// config-register addresses, loader FSM states and the config write record.
package bp_cfg_loader_pkg;

  typedef enum logic [1:0] {
    e_bp_single_core_cfg = 2'd0,
    e_bp_dual_core_cfg   = 2'd1,
    e_bp_quad_core_cfg   = 2'd2,
    e_bp_hexa_core_cfg   = 2'd3
  } bp_params_e;

  typedef struct packed {
    logic [7:0] cc_x_dim;
    logic [7:0] cc_y_dim;
    logic [7:0] ic_y_dim;
  } bp_proc_param_s;

  // Core tiles sit below one row of I/O complex, hence ic_y_dim = 1 everywhere.
  localparam bp_proc_param_s all_cfgs_gp [4] = '{
    '{cc_x_dim: 8'd1, cc_y_dim: 8'd1, ic_y_dim: 8'd1},
    '{cc_x_dim: 8'd2, cc_y_dim: 8'd1, ic_y_dim: 8'd1},
    '{cc_x_dim: 8'd2, cc_y_dim: 8'd2, ic_y_dim: 8'd1},
    '{cc_x_dim: 8'd3, cc_y_dim: 8'd2, ic_y_dim: 8'd1}
  };

  typedef enum logic [15:0] {
    e_cfg_freeze      = 16'h0001,
    e_cfg_core_id     = 16'h0002,
    e_cfg_cord        = 16'h0004,
    e_cfg_icache_mode = 16'h0005,
    e_cfg_dcache_mode = 16'h0006
  } bp_cfg_reg_e;

  typedef enum logic [2:0] {
    e_reset         = 3'd0,
    e_send_cfg      = 3'd1,
    e_drain         = 3'd2,
    e_send_unfreeze = 3'd3,
    e_wait_acks     = 3'd4,
    e_done          = 3'd5
  } bp_cfg_loader_state_e;

  typedef struct packed {
    logic [7:0]  core_id;
    logic [15:0] addr;
    logic [63:0] data;
  } bp_cfg_write_s;

  // Writes issued per core during the configuration pass.
  localparam int unsigned cfg_fields_gp = 5;

  function automatic int unsigned num_core_f(bp_params_e cfg);
    return 32'(all_cfgs_gp[cfg].cc_x_dim) * 32'(all_cfgs_gp[cfg].cc_y_dim);
  endfunction

  // clog2 that never yields a zero-width vector.
  function automatic int unsigned safe_clog2_f(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_cfg_loader_credits.sv
// Tracks writes sent but not yet acked; gates new writes and flags acks that
// arrive with nothing outstanding.
module bp_cfg_loader_credits
  import bp_cfg_loader_pkg::*;
#(
  parameter int unsigned max_outstanding_p = 4,
  localparam int unsigned cnt_width_lp = $clog2(max_outstanding_p + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic accept_i,
  input  logic ack_i,
  output logic credit_avail_o,
  output logic empty_o,
  output logic spurious_ack_o
);

  logic [cnt_width_lp-1:0] cnt_q, cnt_d;

  // Accept+ack in one cycle cancels out; a lone ack at zero is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_i && !ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (ack_i && !accept_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Outstanding-count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign credit_avail_o = (cnt_q < cnt_width_lp'(max_outstanding_p));
  assign empty_o        = (cnt_q == '0);
  assign spurious_ack_o = ack_i && !accept_i && (cnt_q == '0);

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot-time config sequencer: writes freeze/id/cord/cache-mode to every core,
// waits for all acks, then unfreezes every core.
//
// state           | meaning
// e_reset         | one idle cycle after reset
// e_send_cfg      | 5 config writes per core, core 0 first
// e_drain         | wait for every config write to be acked
// e_send_unfreeze | freeze=0 write per core
// e_wait_acks     | wait for unfreeze acks
// e_done          | sequence complete, done_o held until reset
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter bp_params_e  cfg_p             = e_bp_single_core_cfg,
  parameter int unsigned cfg_addr_width_p  = 16,
  parameter int unsigned cfg_data_width_p  = 64,
  parameter int unsigned max_outstanding_p = 4,
  localparam int unsigned num_core_lp      = num_core_f(cfg_p),
  localparam int unsigned core_id_width_lp = safe_clog2_f(num_core_lp)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_id_width_lp-1:0] cfg_core_id_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        ack_v_i,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int unsigned x_dim_lp = 32'(all_cfgs_gp[cfg_p].cc_x_dim);
  localparam int unsigned ic_y_lp  = 32'(all_cfgs_gp[cfg_p].ic_y_dim);
  localparam logic [core_id_width_lp-1:0] last_core_lp = core_id_width_lp'(num_core_lp - 1);
  localparam logic [2:0] last_field_lp = 3'(cfg_fields_gp - 1);

  bp_cfg_loader_state_e        state_q, state_d;
  logic [core_id_width_lp-1:0] core_q, core_d;
  logic [2:0]                  field_q, field_d;
  logic                        err_q, err_d;

  logic        credit_avail, empty, spurious_ack;
  logic        sending, accept;
  logic [7:0]  cord_x, cord_y;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;

  bp_cfg_loader_credits #(.max_outstanding_p(max_outstanding_p)) credits (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .accept_i       (accept),
    .ack_i          (ack_v_i),
    .credit_avail_o (credit_avail),
    .empty_o        (empty),
    .spurious_ack_o (spurious_ack)
  );

  // Valid depends only on state and credits, never on ready.
  assign sending = (state_q == e_send_cfg) || (state_q == e_send_unfreeze);
  assign cfg_v_o = sending && credit_avail;
  assign accept  = cfg_v_o && cfg_ready_i;

  // Address/data of the write for the current core and field.
  always_comb begin
    cord_x  = 8'(32'(core_q) % x_dim_lp);
    cord_y  = 8'(ic_y_lp + 32'(core_q) / x_dim_lp);
    wr_addr = e_cfg_freeze;
    wr_data = 64'd0;
    if (state_q != e_send_unfreeze) begin
      case (field_q)
        3'd0: begin wr_addr = e_cfg_freeze;      wr_data = 64'd1; end
        3'd1: begin wr_addr = e_cfg_core_id;     wr_data = 64'(core_q); end
        3'd2: begin wr_addr = e_cfg_cord;        wr_data = {48'd0, cord_y, cord_x}; end
        3'd3: begin wr_addr = e_cfg_icache_mode; wr_data = 64'd1; end
        default: begin wr_addr = e_cfg_dcache_mode; wr_data = 64'd1; end
      endcase
    end
  end

  assign cfg_core_id_o = cfg_v_o ? core_q : '0;
  assign cfg_addr_o    = cfg_v_o ? cfg_addr_width_p'(wr_addr) : '0;
  assign cfg_data_o    = cfg_v_o ? cfg_data_width_p'(wr_data) : '0;
  assign done_o        = (state_q == e_done);
  assign err_o         = err_q;

  // Next state, core/field advance on each accepted write, sticky error.
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    field_d = field_q;
    err_d   = err_q || spurious_ack;
    case (state_q)
      e_reset: state_d = e_send_cfg;
      e_send_cfg: begin
        if (accept) begin
          if (field_q == last_field_lp) begin
            field_d = '0;
            if (core_q == last_core_lp) begin
              core_d  = '0;
              state_d = e_drain;
            end else begin
              core_d = core_q + 1'b1;
            end
          end else begin
            field_d = field_q + 3'd1;
          end
        end
      end
      e_drain: if (empty) state_d = e_send_unfreeze;
      e_send_unfreeze: begin
        if (accept) begin
          if (core_q == last_core_lp) begin
            core_d  = '0;
            state_d = e_wait_acks;
          end else begin
            core_d = core_q + 1'b1;
          end
        end
      end
      e_wait_acks: if (empty) state_d = e_done;
      default: state_d = state_q;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_reset;
      core_q  <= '0;
      field_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      field_q <= field_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: one instance per processor configuration, random
// ready stalls and ack latencies checked against a write-list model.
module tb_bp_cfg_loader;
  import bp_cfg_loader_pkg::*;

  localparam int x_dim_c [4] = '{1, 2, 2, 3};
  localparam int y_dim_c [4] = '{1, 1, 2, 2};
  localparam int ic_y_c      = 1;
  localparam int max_out_c   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [4];
  logic        rdy  [4];
  logic        ack  [4];
  logic        v    [4];
  logic [7:0]  cid  [4];
  logic [15:0] addr [4];
  logic [63:0] data [4];
  logic        done [4];
  logic        err  [4];

  int n_vec  = 0;
  int n_miss = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int num_l = x_dim_c[g] * y_dim_c[g];
    localparam int cw_l  = (num_l <= 1) ? 1 : $clog2(num_l);
    logic [cw_l-1:0] cid_l;
    bp_cfg_loader #(
      .cfg_p(bp_params_e'(g)), .cfg_addr_width_p(16),
      .cfg_data_width_p(64), .max_outstanding_p(4)
    ) dut (
      .clk_i(clk), .reset_i(rst[g]), .cfg_v_o(v[g]), .cfg_ready_i(rdy[g]),
      .cfg_core_id_o(cid_l), .cfg_addr_o(addr[g]), .cfg_data_o(data[g]),
      .ack_v_i(ack[g]), .done_o(done[g]), .err_o(err[g])
    );
    assign cid[g] = 8'(cid_l);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
    end
  endtask

  // Hold reset two cycles, check idle outputs, release on a falling edge.
  task automatic do_reset(input int k);
    @(negedge clk);
    rst[k] = 1'b1; rdy[k] = 1'b0; ack[k] = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_v", 64'(v[k]), 64'd0);
    check_eq("rst_done", 64'(done[k]), 64'd0);
    check_eq("rst_err", 64'(err[k]), 64'd0);
    check_eq("rst_cid", 64'(cid[k]), 64'd0);
    check_eq("rst_addr", 64'(addr[k]), 64'd0);
    check_eq("rst_data", data[k], 64'd0);
    rst[k] = 1'b0;
  endtask

  task automatic run_case(input int k, input int rdy_pct, input int lat_max,
                          input bit spur_first, input int abort_after, input bit spur_done);
    bp_cfg_write_s exp_q[$];
    int ack_due[$];
    int n, acc, acked, outs, last_due, due;
    bit err_exp, prev_v, prev_acc, r, a, acc_now, fin;
    logic [7:0] p_cid; logic [15:0] p_addr; logic [63:0] p_data;

    n = x_dim_c[k] * y_dim_c[k];
    for (int c = 0; c < n; c++) begin
      exp_q.push_back('{8'(c), 16'h0001, 64'd1});
      exp_q.push_back('{8'(c), 16'h0002, 64'(c)});
      exp_q.push_back('{8'(c), 16'h0004,
                        64'((ic_y_c + c / x_dim_c[k]) * 256 + (c % x_dim_c[k]))});
      exp_q.push_back('{8'(c), 16'h0005, 64'd1});
      exp_q.push_back('{8'(c), 16'h0006, 64'd1});
    end
    for (int c = 0; c < n; c++) exp_q.push_back('{8'(c), 16'h0001, 64'd0});

    do_reset(k);
    err_exp = 1'b0;
    if (spur_first) begin ack[k] = 1'b1; err_exp = 1'b1; end
    acc = 0; acked = 0; outs = 0; last_due = -1; fin = 1'b0;
    prev_v = 1'b0; prev_acc = 1'b0; p_cid = '0; p_addr = '0; p_data = '0;

    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(negedge clk);
      if (spur_first && cyc == 0) check_eq("spur_err", 64'(err[k]), 64'd1);
      if (abort_after > 0 && acc == abort_after) begin
        rst[k] = 1'b1; rdy[k] = 1'b0; ack[k] = 1'b0;
        @(negedge clk);
        check_eq("abort_v", 64'(v[k]), 64'd0);
        check_eq("abort_done", 64'(done[k]), 64'd0);
        check_eq("abort_addr", 64'(addr[k]), 64'd0);
        return;
      end
      if (prev_v && !prev_acc) begin
        check_eq("stall_v", 64'(v[k]), 64'd1);
        check_eq("stall_cid", 64'(cid[k]), 64'(p_cid));
        check_eq("stall_addr", 64'(addr[k]), 64'(p_addr));
        check_eq("stall_data", data[k], p_data);
      end
      if (v[k]) check_eq("credit_limit", 64'(outs < max_out_c), 64'd1);
      if (acc < 5 * n && outs < max_out_c) check_eq("v_cfg_phase", 64'(v[k]), 64'd1);
      if (acc > 5 * n && acc < 6 * n && outs < max_out_c)
        check_eq("v_unfreeze_phase", 64'(v[k]), 64'd1);
      if (acc == 5 * n && acked < 5 * n) check_eq("drain_v", 64'(v[k]), 64'd0);
      if (done[k]) begin
        check_eq("done_complete", 64'(acc == 6 * n && acked == 6 * n), 64'd1);
        check_eq("done_v", 64'(v[k]), 64'd0);
        fin = 1'b1;
      end

      r       = ($urandom_range(99) < rdy_pct);
      acc_now = v[k] && r;
      a       = (ack_due.size() > 0) && (ack_due[0] <= cyc);
      if (a) void'(ack_due.pop_front());
      if (acc_now) begin
        if (acc < 6 * n) begin
          check_eq("wr_cid", 64'(cid[k]), 64'(exp_q[acc].core_id));
          check_eq("wr_addr", 64'(addr[k]), 64'(exp_q[acc].addr));
          check_eq("wr_data", data[k], exp_q[acc].data);
        end else begin
          check_eq("wr_overrun", 64'(acc), 64'(6 * n - 1));
        end
        if (acc == 5 * n) check_eq("unfreeze_after_acks", 64'(acked), 64'(5 * n));
        acc++;
        due = cyc + int'($urandom_range(lat_max, 1));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        ack_due.push_back(due);
      end
      if (a) acked++;
      outs = outs + int'(acc_now) - int'(a);
      rdy[k] = r; ack[k] = a;
      prev_v = v[k]; prev_acc = acc_now;
      p_cid = cid[k]; p_addr = addr[k]; p_data = data[k];
    end

    check_eq("done_seen", 64'(fin), 64'd1);
    check_eq("write_total", 64'(acc), 64'(6 * n));
    check_eq("err_final", 64'(err[k]), 64'(err_exp));
    if (spur_done) begin
      rdy[k] = 1'b0; ack[k] = 1'b1;
      @(negedge clk);
      ack[k] = 1'b0;
      check_eq("done_ack_err", 64'(err[k]), 64'd1);
      check_eq("done_ack_done", 64'(done[k]), 64'd1);
      @(negedge clk);
      check_eq("err_sticky", 64'(err[k]), 64'd1);
    end
    rdy[k] = 1'b0; ack[k] = 1'b0;
  endtask

  // Withhold acks: four writes go out, then valid drops until an ack returns.
  task automatic withhold_case(input int k);
    int acc;
    acc = 0;
    do_reset(k);
    rdy[k] = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (v[k]) acc++;
    end
    check_eq("withhold_accepts", 64'(acc), 64'd4);
    check_eq("withhold_v", 64'(v[k]), 64'd0);
    rdy[k] = 1'b0; ack[k] = 1'b1;
    @(negedge clk);
    ack[k] = 1'b0;
    check_eq("release_v", 64'(v[k]), 64'd1);
    check_eq("release_addr", 64'(addr[k]), 64'h6);
    check_eq("release_cid", 64'(cid[k]), 64'd0);
    rdy[k] = 1'b1; ack[k] = 1'b1;
    @(negedge clk);
    ack[k] = 1'b0;
    check_eq("acc_ack_same_v", 64'(v[k]), 64'd1);
    check_eq("acc_ack_same_addr", 64'(addr[k]), 64'h1);
    check_eq("acc_ack_same_cid", 64'(cid[k]), 64'd1);
    @(negedge clk);
    check_eq("refill_v", 64'(v[k]), 64'd0);
    rdy[k] = 1'b0;
    rst[k] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; rdy[i] = 1'b0; ack[i] = 1'b0;
    end
    run_case(0, 100, 1, 1'b0, 0, 1'b1);
    run_case(2, 60, 6, 1'b0, 0, 1'b0);
    withhold_case(2);
    run_case(1, 100, 3, 1'b1, 0, 1'b0);
    run_case(1, 100, 1, 1'b0, 3, 1'b0);
    run_case(1, 70, 4, 1'b0, 0, 1'b0);
    run_case(3, 100, 1, 1'b0, 0, 1'b0);
    run_case(3, 80, 8, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_case(i % 4, 30 + int'($urandom_range(70)), 1 + int'($urandom_range(7)), 1'b0, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
